cplx_frame_accum: RTL



---
 rtl/cplx_defs.sv | 19 +
 rtl/adder3_complex.sv | 36 +++
 rtl/cplx_frame_accum.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cplx_defs.sv
// Shared definitions for the Q-format complex datapath controllers:
// default format widths, controller state encoding and a signed-add overflow helper.
package cplx_defs;

   localparam int QI_DEF = 3;
   localparam int QF_DEF = 3;

   typedef enum logic [1:0] {
      S_FIRST  = 2'd0,
      S_SECOND = 2'd1,
      S_OUT    = 2'd2
   } state_t;

   // Two's-complement add overflows when both operands share a sign the result lacks.
   function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_y);
      return (sign_a == sign_b) && (sign_y != sign_a);
   endfunction

endpackage

// File: rtl/adder3_complex.sv
// Three-operand complex adder, wrapping modulo 2^WIDTH; the flag reports an
// overflow in either the a+b partial step or the final +c step, on Re or Im.
module adder3_complex
   import cplx_defs::*;
#(
   parameter int QI = QI_DEF,
   parameter int QF = QF_DEF,
   localparam int WIDTH = QI + QF
) (
   input  logic signed [WIDTH-1:0] a_re,
   input  logic signed [WIDTH-1:0] a_im,
   input  logic signed [WIDTH-1:0] b_re,
   input  logic signed [WIDTH-1:0] b_im,
   input  logic signed [WIDTH-1:0] c_re,
   input  logic signed [WIDTH-1:0] c_im,
   output logic signed [WIDTH-1:0] y_re,
   output logic signed [WIDTH-1:0] y_im,
   output logic                    ovf
);

   logic signed [WIDTH-1:0] p_re;
   logic signed [WIDTH-1:0] p_im;

   // Partial then final sum; each step is checked so a later term cannot mask an overflow.
   always_comb begin
      p_re = a_re + b_re;
      p_im = a_im + b_im;
      y_re = p_re + c_re;
      y_im = p_im + c_im;
      ovf  = add_ovf(a_re[WIDTH-1], b_re[WIDTH-1], p_re[WIDTH-1])
           | add_ovf(p_re[WIDTH-1], c_re[WIDTH-1], y_re[WIDTH-1])
           | add_ovf(a_im[WIDTH-1], b_im[WIDTH-1], p_im[WIDTH-1])
           | add_ovf(p_im[WIDTH-1], c_im[WIDTH-1], y_im[WIDTH-1]);
   end

endmodule

// File: rtl/cplx_frame_accum.sv
// Sums FRAME_LEN complex samples per frame through one shared three-input adder,
// consuming up to two samples per accumulator update, with a sticky overflow flag.
module cplx_frame_accum
   import cplx_defs::*;
#(
   parameter int QI        = QI_DEF,
   parameter int QF        = QF_DEF,
   parameter int FRAME_LEN = 8,
   localparam int WIDTH    = QI + QF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic signed [WIDTH-1:0] s_Re,
   input  logic signed [WIDTH-1:0] s_Im,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic signed [WIDTH-1:0] m_Re,
   output logic signed [WIDTH-1:0] m_Im,
   output logic                    m_overflow
);

   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
   localparam logic signed [WIDTH-1:0] ZERO = '0;

   state_t                  state, state_n;
   logic signed [WIDTH-1:0] acc_re, acc_im, acc_re_n, acc_im_n;
   logic signed [WIDTH-1:0] hold_re, hold_im, hold_re_n, hold_im_n;
   logic [CW-1:0]           cnt, cnt_n;
   logic                    ovf_sticky, ovf_sticky_n;
   logic                    m_valid_n, m_overflow_n;
   logic signed [WIDTH-1:0] m_re_n, m_im_n;

   logic signed [WIDTH-1:0] op_b_re, op_b_im, op_c_re, op_c_im;
   logic signed [WIDTH-1:0] sum_re, sum_im;
   logic                    sum_ovf;
   logic                    accept, is_last;

   // Operand selection: the held sample pairs with the new one in S_SECOND.
   always_comb begin
      if (state == S_SECOND) begin
         op_b_re = hold_re;
         op_b_im = hold_im;
         op_c_re = s_Re;
         op_c_im = s_Im;
      end else begin
         op_b_re = s_Re;
         op_b_im = s_Im;
         op_c_re = ZERO;
         op_c_im = ZERO;
      end
   end

   adder3_complex #(.QI(QI), .QF(QF)) u_adder (
      .a_re (acc_re),
      .a_im (acc_im),
      .b_re (op_b_re),
      .b_im (op_b_im),
      .c_re (op_c_re),
      .c_im (op_c_im),
      .y_re (sum_re),
      .y_im (sum_im),
      .ovf  (sum_ovf)
   );

   assign s_ready = (state != S_OUT);
   assign accept  = s_valid && s_ready;
   assign is_last = (cnt == LAST_CNT);

   // Next-state and next-register values; every register holds unless its path fires.
   always_comb begin
      state_n      = state;
      acc_re_n     = acc_re;
      acc_im_n     = acc_im;
      hold_re_n    = hold_re;
      hold_im_n    = hold_im;
      cnt_n        = cnt;
      ovf_sticky_n = ovf_sticky;
      m_valid_n    = m_valid;
      m_re_n       = m_Re;
      m_im_n       = m_Im;
      m_overflow_n = m_overflow;
      case (state)
         S_FIRST: begin
            if (accept && is_last) begin
               m_re_n       = sum_re;
               m_im_n       = sum_im;
               m_overflow_n = ovf_sticky | sum_ovf;
               m_valid_n    = 1'b1;
               state_n      = S_OUT;
            end else if (accept) begin
               hold_re_n = s_Re;
               hold_im_n = s_Im;
               cnt_n     = cnt + CW'(1);
               state_n   = S_SECOND;
            end else begin
               state_n = S_FIRST;
            end
         end
         S_SECOND: begin
            if (accept && is_last) begin
               m_re_n       = sum_re;
               m_im_n       = sum_im;
               m_overflow_n = ovf_sticky | sum_ovf;
               m_valid_n    = 1'b1;
               state_n      = S_OUT;
            end else if (accept) begin
               acc_re_n     = sum_re;
               acc_im_n     = sum_im;
               ovf_sticky_n = ovf_sticky | sum_ovf;
               cnt_n        = cnt + CW'(1);
               state_n      = S_FIRST;
            end else begin
               state_n = S_SECOND;
            end
         end
         S_OUT: begin
            // Output registers keep their values after the handshake; only the frame state clears.
            if (m_ready) begin
               m_valid_n    = 1'b0;
               acc_re_n     = ZERO;
               acc_im_n     = ZERO;
               hold_re_n    = ZERO;
               hold_im_n    = ZERO;
               ovf_sticky_n = 1'b0;
               cnt_n        = '0;
               state_n      = S_FIRST;
            end else begin
               state_n = S_OUT;
            end
         end
         default: begin
            state_n = S_FIRST;
         end
      endcase
   end

   // Register update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_FIRST;
         acc_re     <= ZERO;
         acc_im     <= ZERO;
         hold_re    <= ZERO;
         hold_im    <= ZERO;
         cnt        <= '0;
         ovf_sticky <= 1'b0;
         m_valid    <= 1'b0;
         m_Re       <= ZERO;
         m_Im       <= ZERO;
         m_overflow <= 1'b0;
      end else begin
         state      <= state_n;
         acc_re     <= acc_re_n;
         acc_im     <= acc_im_n;
         hold_re    <= hold_re_n;
         hold_im    <= hold_im_n;
         cnt        <= cnt_n;
         ovf_sticky <= ovf_sticky_n;
         m_valid    <= m_valid_n;
         m_Re       <= m_re_n;
         m_Im       <= m_im_n;
         m_overflow <= m_overflow_n;
      end
   end

endmodule
